// File: rtl/panel_pkg.sv
// Shared constants and the per-LED mode decode for the front-panel / status controller.
package panel_pkg;

    localparam logic [1:0] LED_OFF    = 2'b00;
    localparam logic [1:0] LED_ON     = 2'b01;
    localparam logic [1:0] LED_BLINK  = 2'b10;
    localparam logic [1:0] LED_FOLLOW = 2'b11;

    localparam int unsigned CLK_HZ             = 5_000_000;
    localparam logic [7:0]  PATTERN_ON_DEFAULT = 8'hB6;

    // Next LED level for one channel given its mode, the blink phase and its follow switch
    function automatic logic led_drive(input logic [1:0] mode,
                                       input logic       phase,
                                       input logic       follow);
        logic lvl;
        lvl = 1'b0;
        case (mode)
            LED_OFF:    lvl = 1'b0;
            LED_ON:     lvl = 1'b1;
            LED_BLINK:  lvl = phase;
            LED_FOLLOW: lvl = follow;
            default:    lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-FF synchroniser, restart-on-bounce debounce counter, change pulse.
module sw_debounce #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic clk_5m,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_change
);

    localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_d;
    logic             change_d;

    assign sync = sync_q[1];

    // Any agreeing cycle clears the count, so a bounce restarts the whole window
    always_comb begin
        cnt_d    = '0;
        db_d     = sw_db;
        change_d = 1'b0;
        if (sync != sw_db) begin
            if (cnt_q == CNT_LAST) begin
                db_d     = sync;
                change_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_5m or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            sw_db     <= 1'b0;
            sw_change <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], sw_raw};
            cnt_q     <= cnt_d;
            sw_db     <= db_d;
            sw_change <= change_d;
        end
    end

endmodule

// File: rtl/panel_status_ctrl.sv
// Front-panel switch debounce, per-channel LED modes (off/on/blink/follow) and the
// EIM status word, all in the 5 MHz housekeeping domain.
module panel_status_ctrl
    import panel_pkg::*;
#(
    parameter int unsigned         NUM_SW      = 4,
    parameter int unsigned         NUM_LED     = 4,
    parameter int unsigned         DEB_CYCLES  = 50000,
    parameter int unsigned         TICK_DIV    = 500000,
    parameter int unsigned         BLINK_TICKS = 5,
    parameter int unsigned         STATUS_W    = 8,
    parameter logic [STATUS_W-1:0] PATTERN_ON  = STATUS_W'(PATTERN_ON_DEFAULT)
) (
    input  logic                  clk_5m,
    input  logic                  reset,
    input  logic [NUM_SW-1:0]     sw_raw,
    input  logic [2*NUM_LED-1:0]  led_mode,
    output logic [NUM_LED-1:0]    led,
    output logic [NUM_SW-1:0]     sw_db,
    output logic [NUM_SW-1:0]     sw_change,
    output logic                  sw_any,
    output logic                  tick,
    output logic [STATUS_W-1:0]   status_word
);

    localparam int unsigned      PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_NEAR = PRE_W'(TICK_DIV - 2);
    localparam int unsigned      BLK_W    = $clog2(BLINK_TICKS + 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    logic [PRE_W-1:0]   pre_cnt;
    logic [BLK_W-1:0]   blink_cnt;
    logic               blink_phase;
    logic [NUM_LED-1:0] led_d;

    for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk_5m    (clk_5m),
            .reset     (reset),
            .sw_raw    (sw_raw[s]),
            .sw_db     (sw_db[s]),
            .sw_change (sw_change[s])
        );
    end

    assign sw_any = |sw_db;

    // tick is decoded one count early so the registered pulse lines up with the wrap cycle
    always_ff @(posedge clk_5m or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
            tick    <= (pre_cnt == PRE_NEAR);
        end
    end

    always_ff @(posedge clk_5m or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // LEDs beyond the switch count wrap around onto the available switches
    for (genvar i = 0; i < NUM_LED; i++) begin : g_led
        localparam int unsigned SW_IDX = i % NUM_SW;
        assign led_d[i] = led_drive(led_mode[2*i +: 2], blink_phase, sw_db[SW_IDX]);
    end

    always_ff @(posedge clk_5m or posedge reset) begin
        if (reset) begin
            led         <= '0;
            status_word <= '0;
        end else begin
            led         <= led_d;
            status_word <= sw_any ? PATTERN_ON : '0;
        end
    end

endmodule

// File: tb/tb_panel_status_ctrl.sv
// Directed bench for panel_status_ctrl with a shortened debounce, prescaler and blink period.
module tb_panel_status_ctrl;

    logic       clk_5m;
    logic       reset;
    logic [3:0] sw_raw;
    logic [7:0] led_mode;
    logic [3:0] led;
    logic [3:0] sw_db;
    logic [3:0] sw_change;
    logic       sw_any;
    logic       tick;
    logic [7:0] status_word;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    panel_status_ctrl #(
        .NUM_SW      (4),
        .NUM_LED     (4),
        .DEB_CYCLES  (4),
        .TICK_DIV    (10),
        .BLINK_TICKS (2),
        .STATUS_W    (8),
        .PATTERN_ON  (8'hB6)
    ) dut (
        .clk_5m      (clk_5m),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .led_mode    (led_mode),
        .led         (led),
        .sw_db       (sw_db),
        .sw_change   (sw_change),
        .sw_any      (sw_any),
        .tick        (tick),
        .status_word (status_word)
    );

    initial clk_5m = 1'b0;
    always #5 clk_5m = ~clk_5m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance to just after rising edge k (counted from reset release)
    task automatic adv_to(input int k);
        while (cyc < k) begin
            @(posedge clk_5m);
            cyc++;
        end
        #2;
    endtask

    initial begin
        reset    = 1'b1;
        sw_raw   = 4'hF;
        led_mode = 8'hAA;
        #23;
        check("rst_led",    32'(led),         32'h0);
        check("rst_sw_db",  32'(sw_db),       32'h0);
        check("rst_change", 32'(sw_change),   32'h0);
        check("rst_tick",   32'(tick),        32'h0);
        check("rst_status", 32'(status_word), 32'h0);
        check("rst_any",    32'(sw_any),      32'h0);
        @(posedge clk_5m);
        #2;
        reset = 1'b0;
        cyc   = 0;

        // Switch latency: 2 sync + 4 debounce cycles
        adv_to(5);
        check("deb_early",  32'(sw_db),       32'h0);
        adv_to(6);
        check("deb_db",     32'(sw_db),       32'hF);
        check("deb_pulse",  32'(sw_change),   32'hF);
        check("deb_any",    32'(sw_any),      32'h1);
        check("deb_status0",32'(status_word), 32'h0);
        adv_to(7);
        check("deb_pulse1", 32'(sw_change),   32'h0);
        check("status_on",  32'(status_word), 32'hB6);

        // Prescaler and blink
        adv_to(8);
        check("tick_8",  32'(tick), 32'h0);
        adv_to(9);
        check("tick_9",  32'(tick), 32'h1);
        adv_to(10);
        check("tick_10", 32'(tick), 32'h0);
        adv_to(19);
        check("tick_19", 32'(tick), 32'h1);
        adv_to(20);
        check("blink_20", 32'(led), 32'h0);
        adv_to(21);
        check("blink_21", 32'(led), 32'hF);
        adv_to(40);
        check("blink_40", 32'(led), 32'hF);
        adv_to(41);
        check("blink_41", 32'(led), 32'h0);

        // Bounce on switch 0 (1->0 with a short return to 1) restarts the window
        sw_raw = 4'hE;
        for (int k = 42; k <= 50; k++) begin
            adv_to(k);
            if (k == 43) sw_raw = 4'hF;
            if (k == 45) sw_raw = 4'hE;
            check("bounce_db",    32'(sw_db),     32'hF);
            check("bounce_pulse", 32'(sw_change), 32'h0);
        end
        adv_to(51);
        check("bounce_db_acc",    32'(sw_db),     32'hE);
        check("bounce_pulse_acc", 32'(sw_change), 32'h1);
        adv_to(52);
        check("bounce_pulse_end", 32'(sw_change), 32'h0);

        // Mixed modes: led3 follow, led2 on, led1 off, led0 blink
        sw_raw = 4'h8;
        adv_to(58);
        check("mix_db",    32'(sw_db),     32'h8);
        check("mix_pulse", 32'(sw_change), 32'h6);
        led_mode = 8'hD2;
        adv_to(59);
        check("mix_led_59", 32'(led), 32'hC);
        adv_to(61);
        check("mix_led_61", 32'(led), 32'hD);
        sw_raw = 4'h0;
        adv_to(67);
        check("follow_db",    32'(sw_db),       32'h0);
        check("follow_pulse", 32'(sw_change),   32'h8);
        check("follow_led_h", 32'(led),         32'hD);
        check("follow_stat_h",32'(status_word), 32'hB6);
        adv_to(68);
        check("follow_led",   32'(led),         32'h5);
        check("status_off",   32'(status_word), 32'h0);
        check("any_off",      32'(sw_any),      32'h0);

        // Status word 0 -> B6 -> 0 on a single switch
        sw_raw = 4'h2;
        adv_to(74);
        check("stat_db_2",   32'(sw_db),       32'h2);
        check("stat_lag_on", 32'(status_word), 32'h0);
        adv_to(75);
        check("stat_on_2",   32'(status_word), 32'hB6);
        sw_raw = 4'h0;
        adv_to(81);
        check("stat_db_0",    32'(sw_db),       32'h0);
        check("stat_lag_off", 32'(status_word), 32'hB6);
        adv_to(82);
        check("stat_off",     32'(status_word), 32'h0);
        check("stat_led",     32'(led),         32'h4);

        // Reset in the middle of a debounce window while blink_phase is 1
        adv_to(98);
        sw_raw = 4'hF;
        adv_to(102);
        check("pre_rst_led", 32'(led),   32'h5);
        check("pre_rst_db",  32'(sw_db), 32'h0);
        reset = 1'b1;
        #1;
        check("mid_rst_led",    32'(led),         32'h0);
        check("mid_rst_db",     32'(sw_db),       32'h0);
        check("mid_rst_status", 32'(status_word), 32'h0);
        check("mid_rst_tick",   32'(tick),        32'h0);
        repeat (2) @(posedge clk_5m);
        #2;
        reset = 1'b0;
        cyc   = 0;
        adv_to(5);
        check("re_deb_early", 32'(sw_db),     32'h0);
        adv_to(6);
        check("re_deb_db",    32'(sw_db),     32'hF);
        check("re_deb_pulse", 32'(sw_change), 32'hF);
        adv_to(7);
        check("re_status",    32'(status_word), 32'hB6);
        check("re_led_7",     32'(led),         32'hC);
        adv_to(9);
        check("re_tick_9",    32'(tick),        32'h1);
        adv_to(20);
        check("re_blink_20",  32'(led),         32'hC);
        adv_to(21);
        check("re_blink_21",  32'(led),         32'hD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
